alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 39 +++
 rtl/alu_sequencer_reg_file.sv | 35 +++
 rtl/alu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared widths, instruction field positions, opcodes and FSM state encoding
// for the ALU sequencer and its register file.
package alu_sequencer_pkg;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned INSTR_W   = 9;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned REG_SEL_W = 2;
    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned IMM_W     = 4;
    localparam int unsigned SHAMT_W   = 3;

    // Bit positions of the instruction fields; s overlaps the upper half of imm
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned D_LSB   = 4;
    localparam int unsigned S_LSB   = 2;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_XOR  = 3'b000;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b010;
    localparam logic [OP_W-1:0] OP_ANDI = 3'b011;
    localparam logic [OP_W-1:0] OP_RLS  = 3'b100;
    localparam logic [OP_W-1:0] OP_HALT = 3'b101;

    // Register holding the branch target
    localparam logic [REG_SEL_W-1:0] BRANCH_REG = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/alu_sequencer_reg_file.sv
// 4x8 register file: one write port, two combinational read ports, a debug
// read port and a fixed tap on the branch-target register.
module reg_file4x8
    import alu_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_SEL_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_SEL_W-1:0] raddr1,
    output logic [DATA_W-1:0]    rdata1_c,
    input  logic [REG_SEL_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata2_c,
    input  logic [REG_SEL_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data_c,
    output logic [DATA_W-1:0]    r3_data_c
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1_c   = regs[raddr1];
    assign rdata2_c   = regs[raddr2];
    assign dbg_data_c = regs[dbg_sel];
    assign r3_data_c  = regs[BRANCH_REG];
endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute sequencer driving an external combinational ALU over a
// four-register machine; one instruction per FETCH+EXEC pair.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_PC = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_valid,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [OP_W-1:0]      alu_op,
    output logic [DATA_W-1:0]    alu_in1,
    output logic [DATA_W-1:0]    alu_in2,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_zero,
    output logic                 done,
    output logic                 error,
    input  logic [REG_SEL_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data
);
    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_W-1:0]      pc;
    logic [ADDR_W-1:0]      pc_nxt;
    logic [INSTR_W-1:0]     ir;
    logic [INSTR_W-1:0]     ir_nxt;
    logic                   done_nxt;
    logic                   error_nxt;
    logic                   req_nxt;
    logic                   rf_we;
    logic [DATA_W-1:0]      rd1;
    logic [DATA_W-1:0]      rd2;
    logic [DATA_W-1:0]      r3;
    logic [OP_W-1:0]        op;
    logic [REG_SEL_W-1:0]   d;
    logic [REG_SEL_W-1:0]   s;
    logic [IMM_W-1:0]       imm;

    assign op        = ir[OP_LSB +: OP_W];
    assign d         = ir[D_LSB +: REG_SEL_W];
    assign s         = ir[S_LSB +: REG_SEL_W];
    assign imm       = ir[IMM_LSB +: IMM_W];
    assign imem_addr = pc;

    reg_file4x8 u_reg_file (
        .clk        (clk),
        .reset      (reset),
        .we         (rf_we),
        .waddr      (d),
        .wdata      (alu_result),
        .raddr1     (d),
        .rdata1_c   (rd1),
        .raddr2     (s),
        .rdata2_c   (rd2),
        .dbg_sel    (dbg_sel),
        .dbg_data_c (dbg_data),
        .r3_data_c  (r3)
    );

    // State and architectural registers; reset drops imem_req without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= START_PC;
            ir       <= '0;
            imem_req <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir       <= ir_nxt;
            imem_req <= req_nxt;
            done     <= done_nxt;
            error    <= error_nxt;
        end
    end

    // Next-state, register-file write and ALU drive
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        done_nxt  = done;
        error_nxt = error;
        rf_we     = 1'b0;
        alu_op    = '0;
        alu_in1   = '0;
        alu_in2   = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = START_PC;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_nxt    = imem_data;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                pc_nxt    = pc + ADDR_W'(1);
                case (op)
                    OP_XOR: begin
                        alu_op  = OP_XOR;
                        alu_in1 = rd1;
                        alu_in2 = rd2;
                        rf_we   = 1'b1;
                    end
                    OP_BEQ: begin
                        alu_op  = OP_BEQ;
                        alu_in1 = rd1;
                        alu_in2 = rd2;
                        if (alu_zero) begin
                            pc_nxt = r3;
                        end
                    end
                    OP_ADDI: begin
                        alu_op  = OP_ADDI;
                        alu_in1 = rd1;
                        alu_in2 = sext_imm(imm);
                        rf_we   = 1'b1;
                    end
                    OP_ANDI: begin
                        alu_op  = OP_ANDI;
                        alu_in1 = rd1;
                        alu_in2 = DATA_W'(imm);
                        rf_we   = 1'b1;
                    end
                    OP_RLS: begin
                        alu_op  = OP_RLS;
                        alu_in1 = rd1;
                        alu_in2 = DATA_W'(imm[SHAMT_W-1:0]);
                        rf_we   = 1'b1;
                    end
                    OP_HALT: begin
                        state_nxt = ST_HALTED;
                        pc_nxt    = pc;
                        done_nxt  = 1'b1;
                    end
                    default: begin
                        state_nxt = ST_HALTED;
                        pc_nxt    = pc;
                        error_nxt = 1'b1;
                    end
                endcase
            end
            ST_HALTED: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = START_PC;
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        req_nxt = (state_nxt == ST_FETCH);
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, instruction memory
// responder and an instruction-level reference model of the machine.
module tb_alu_sequencer;
    localparam logic [7:0] START = 8'hFC;
    localparam logic [8:0] HALT_W = 9'b101_000000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid = 1'b0;
    logic [8:0] imem_data = '0;
    logic [2:0] alu_op;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       done;
    logic       error;
    logic [1:0] dbg_sel = '0;
    logic [7:0] dbg_data;

    int checks = 0;
    int failures = 0;

    logic [8:0] imem [256];
    logic [7:0] m_r [4];
    logic [7:0] m_pc;
    bit         m_done;
    bit         m_err;
    logic [7:0] last_fetch;
    logic [15:0] rot;

    always #5 clk = ~clk;

    alu_sequencer #(.START_PC(START)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .alu_op     (alu_op),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .done       (done),
        .error      (error),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    // External combinational ALU
    always_comb begin
        alu_result = 8'h00;
        rot = {alu_in1, alu_in1} << alu_in2[2:0];
        case (alu_op)
            3'd0: alu_result = alu_in1 ^ alu_in2;
            3'd1: alu_result = alu_in1 - alu_in2;
            3'd2: alu_result = alu_in1 + alu_in2;
            3'd3: alu_result = alu_in1 & alu_in2;
            3'd4: alu_result = rot[15:8];
            default: alu_result = 8'h00;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [1:0] d, input logic [3:0] imm);
        return {op, d, imm};
    endfunction

    function automatic int simm(input logic [3:0] imm);
        return imm[3] ? int'(imm) - 16 : int'(imm);
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = HALT_W;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_pc = START;
        m_done = 0;
        m_err = 0;
    endtask

    // One instruction at the architectural level
    task automatic m_exec(input logic [8:0] w);
        logic [2:0] op;
        logic [1:0] d;
        logic [1:0] s;
        logic [3:0] imm;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] v;
        op = w[8:6]; d = w[5:4]; s = w[3:2]; imm = w[3:0];
        a = m_r[d]; b = m_r[s];
        case (op)
            3'd0: begin m_r[d] = a ^ b; m_pc = m_pc + 8'd1; end
            3'd1: m_pc = (a == b) ? m_r[3] : m_pc + 8'd1;
            3'd2: begin m_r[d] = 8'(int'(a) + simm(imm)); m_pc = m_pc + 8'd1; end
            3'd3: begin m_r[d] = a & {4'h0, imm}; m_pc = m_pc + 8'd1; end
            3'd4: begin
                v = a;
                for (int k = 0; k < int'(imm[2:0]); k++) v = {v[6:0], v[7]};
                m_r[d] = v;
                m_pc = m_pc + 8'd1;
            end
            3'd5: m_done = 1;
            default: m_err = 1;
        endcase
    endtask

    // Starts the machine, serves fetches with random latency and checks each step
    task automatic run_prog(input int min_w, input int max_w, input int max_instr, output int cycles);
        int wait_left;
        int n_instr;
        int budget;
        bit exec_pending;
        bit in_fetch;
        logic [8:0] cur;
        logic [7:0] held;
        logic [2:0] e_op;
        logic [7:0] a;
        logic [7:0] e_in2;
        budget = (max_w + 2) * (max_instr + 2) + 10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_pc = START; m_done = 0; m_err = 0;
        checks++;
        if (done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL start_clear done=%b error=%b required 0/0", done, error);
        end
        cycles = 0; n_instr = 0; exec_pending = 0; in_fetch = 0; wait_left = 0;
        held = '0; cur = '0;
        forever begin
            if (exec_pending) begin
                e_op = cur[8:6];
                a = m_r[cur[5:4]];
                case (e_op)
                    3'd0, 3'd1: e_in2 = m_r[cur[3:2]];
                    3'd2: e_in2 = 8'(simm(cur[3:0]));
                    3'd3: e_in2 = {4'h0, cur[3:0]};
                    3'd4: e_in2 = {5'h00, cur[2:0]};
                    default: e_in2 = 8'h00;
                endcase
                if (e_op <= 3'd4) begin
                    checks++;
                    if (alu_op !== e_op || alu_in1 !== a || alu_in2 !== e_in2) begin
                        failures++;
                        $display("FAIL exec_alu got op=%h in1=%h in2=%h required op=%h in1=%h in2=%h",
                                 alu_op, alu_in1, alu_in2, e_op, a, e_in2);
                    end
                end
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL exec_req imem_req=%b required 0", imem_req);
                end
                m_exec(cur);
                exec_pending = 0;
                n_instr++;
                imem_valid = 1'($urandom);
                imem_data = 9'($urandom);
                start = ($urandom_range(0, 3) == 0);
            end else if (m_done || m_err) begin
                break;
            end else if (imem_req === 1'b1) begin
                checks++;
                if (!in_fetch) begin
                    if (imem_addr !== m_pc) begin
                        failures++;
                        $display("FAIL fetch_addr got %h required %h", imem_addr, m_pc);
                    end
                    held = m_pc;
                    in_fetch = 1;
                    wait_left = $urandom_range(min_w, max_w);
                end else if (imem_addr !== held) begin
                    failures++;
                    $display("FAIL fetch_hold got %h required %h", imem_addr, held);
                end
                checks++;
                if (alu_op !== 3'd0 || alu_in1 !== 8'h00 || alu_in2 !== 8'h00) begin
                    failures++;
                    $display("FAIL alu_idle got op=%h in1=%h in2=%h required 0/00/00", alu_op, alu_in1, alu_in2);
                end
                if (wait_left == 0) begin
                    cur = (n_instr >= max_instr) ? HALT_W : imem[held];
                    imem_valid = 1'b1;
                    imem_data = cur;
                    exec_pending = 1;
                    in_fetch = 0;
                    last_fetch = held;
                end else begin
                    imem_valid = 1'b0;
                    imem_data = 9'($urandom);
                    wait_left--;
                end
                start = ($urandom_range(0, 3) == 0);
            end else begin
                checks++; failures++;
                $display("FAIL fetch_missing imem_req=%b required 1 (model pc %h)", imem_req, m_pc);
                break;
            end
            if (cycles >= budget) begin
                checks++; failures++;
                $display("FAIL run_timeout cycles=%0d required < %0d", cycles, budget);
                break;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        imem_valid = 1'b0;
        checks++;
        if (done !== 1'(m_done) || error !== 1'(m_err)) begin
            failures++;
            $display("FAIL halt_flags got done=%b error=%b required %b/%b", done, error, m_done, m_err);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checks++;
            if (dbg_data !== m_r[i]) begin
                failures++;
                $display("FAIL reg_R%0d got %h required %h", i, dbg_data, m_r[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; imem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (imem_req !== 1'b0 || done !== 1'b0 || error !== 1'b0 || imem_addr !== START) begin
            failures++;
            $display("FAIL reset_outputs got req=%b done=%b err=%b addr=%h required 0/0/0/%h",
                     imem_req, done, error, imem_addr, START);
        end
        checks++;
        if (alu_op !== 3'd0 || alu_in1 !== 8'h00 || alu_in2 !== 8'h00) begin
            failures++;
            $display("FAIL reset_alu got op=%h in1=%h in2=%h required zeros", alu_op, alu_in1, alu_in2);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_valid = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (imem_req !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold cycle %0d imem_req=%b required 0", i, imem_req);
            end
        end
        imem_valid = 1'b0;
    endtask

    task automatic test_addi_halt();
        int cyc;
        fill_halt();
        imem[START] = enc(3'd2, 2'd1, 4'h5);
        run_prog(0, 0, 20, cyc);
        checks++;
        if (cyc != 4 || done !== 1'b1) begin
            failures++;
            $display("FAIL addi_halt_latency got cycles=%0d done=%b required 4/1", cyc, done);
        end
        dbg_sel = 2'd1; #1;
        checks++;
        if (dbg_data !== 8'h05) begin
            failures++;
            $display("FAIL addi_r1 got %h required 05", dbg_data);
        end
    endtask

    task automatic test_alu_ops_wrap();
        int cyc;
        fill_halt();
        imem[8'hFC] = enc(3'd2, 2'd1, 4'hA);
        imem[8'hFD] = enc(3'd3, 2'd1, 4'h3);
        imem[8'hFE] = enc(3'd4, 2'd1, 4'h2);
        imem[8'hFF] = enc(3'd2, 2'd2, 4'h0);
        run_prog(5, 5, 20, cyc);
        checks++;
        if (last_fetch !== 8'h00) begin
            failures++;
            $display("FAIL pc_wrap last fetch %h required 00", last_fetch);
        end
        dbg_sel = 2'd1; #1;
        checks++;
        if (dbg_data !== 8'h0C) begin
            failures++;
            $display("FAIL alu_ops_r1 got %h required 0C", dbg_data);
        end
    endtask

    task automatic test_branch();
        int cyc;
        fill_halt();
        imem[8'hFC] = enc(3'd2, 2'd3, 4'h7);
        imem[8'hFD] = enc(3'd2, 2'd3, 4'h7);
        imem[8'hFE] = enc(3'd1, 2'd0, 4'b1000);
        imem[8'h0E] = enc(3'd3, 2'd3, 4'h4);
        imem[8'h0F] = enc(3'd4, 2'd3, 4'h4);
        imem[8'h10] = enc(3'd1, 2'd0, 4'b1000);
        run_prog(0, 2, 20, cyc);
        checks++;
        if (last_fetch !== 8'h40) begin
            failures++;
            $display("FAIL beq_taken halt fetched at %h required 40", last_fetch);
        end
        fill_halt();
        imem[8'hFC] = enc(3'd2, 2'd2, 4'h1);
        imem[8'hFD] = enc(3'd3, 2'd3, 4'h0);
        imem[8'hFE] = enc(3'd2, 2'd3, 4'h4);
        imem[8'hFF] = enc(3'd4, 2'd3, 4'h2);
        imem[8'h00] = enc(3'd1, 2'd0, 4'b0000);
        imem[8'h10] = enc(3'd1, 2'd0, 4'b1000);
        run_prog(0, 2, 20, cyc);
        checks++;
        if (last_fetch !== 8'h11) begin
            failures++;
            $display("FAIL beq_not_taken halt fetched at %h required 11", last_fetch);
        end
    endtask

    task automatic test_illegal();
        int cyc;
        logic [7:0] snap [4];
        for (int i = 0; i < 4; i++) snap[i] = m_r[i];
        fill_halt();
        imem[START] = 9'b110_010101;
        run_prog(0, 2, 20, cyc);
        checks++;
        if (error !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL illegal_flags got error=%b done=%b required 1/0", error, done);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            checks++;
            if (dbg_data !== snap[i]) begin
                failures++;
                $display("FAIL illegal_keep_R%0d got %h required %h", i, dbg_data, snap[i]);
            end
        end
        fill_halt();
        run_prog(0, 1, 20, cyc);
        checks++;
        if (last_fetch !== START || error !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL restart got fetch=%h error=%b done=%b required %h/0/1", last_fetch, error, done, START);
        end
    endtask

    task automatic test_random();
        int cyc;
        int r;
        logic [2:0] op;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 256; i++) begin
                r = $urandom_range(0, 99);
                if (r < 90) op = 3'($urandom_range(0, 4));
                else if (r < 95) op = 3'd5;
                else op = 3'($urandom_range(6, 7));
                imem[i] = {op, 6'($urandom)};
            end
            run_prog(0, 3, 30, cyc);
        end
    endtask

    task automatic test_reset_mid_fetch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        imem_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_fetch_entry imem_req=%b required 1", imem_req);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (imem_req !== 1'b0 || done !== 1'b0 || error !== 1'b0 || imem_addr !== START) begin
            failures++;
            $display("FAIL async_reset got req=%b done=%b err=%b addr=%h required 0/0/0/%h",
                     imem_req, done, error, imem_addr, START);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            checks++;
            if (dbg_data !== 8'h00) begin
                failures++;
                $display("FAIL async_reset_R%0d got %h required 00", i, dbg_data);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (imem_req !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle cycle %0d imem_req=%b required 0", i, imem_req);
            end
        end
        imem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi_halt();
        test_alu_ops_wrap();
        test_branch();
        test_illegal();
        test_random();
        test_reset_mid_fetch();
        test_addi_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
